// File: rtl/noc_req_arbiter_if.sv
// Request-side bundle between the control FSM array and the NoC request
// arbiter. The arbiter uses the slave view; the FSM array / NoC side uses master.
interface noc_req_arbiter_if #(
  parameter int N_REQ             = 4,
  parameter int ADDR_W            = 10,
  parameter int ADDR_W_ENCODING_W = 3,
  parameter int OPCODE_W          = 2,
  parameter int SRC_ID_W          = 4
);
  // Per-requester request side (flattened, requester i at [i*W +: W])
  logic [N_REQ-1:0]                   req_valid;
  logic [N_REQ*ADDR_W-1:0]            req_addr;
  logic [N_REQ*ADDR_W_ENCODING_W-1:0] req_width;
  logic [N_REQ*SRC_ID_W-1:0]          req_dest;
  logic [N_REQ*OPCODE_W-1:0]          req_opcode;
  logic [N_REQ-1:0]                   req_is_mem;
  logic [N_REQ-1:0]                   arb_won;
  logic [N_REQ-1:0]                   ack;
  logic                               hold_off;

  // Shared NoC request port
  logic                               out_valid;
  logic                               out_ready;
  logic [ADDR_W-1:0]                  out_addr;
  logic [ADDR_W_ENCODING_W-1:0]       out_width;
  logic [SRC_ID_W-1:0]                out_dest;
  logic [OPCODE_W-1:0]                out_opcode;
  logic                               out_is_mem;
  logic [SRC_ID_W-1:0]                out_source_id;

  // Returning acks and tracking
  logic                               ack_in_valid;
  logic [SRC_ID_W-1:0]                ack_in_src_id;
  logic [N_REQ-1:0]                   outstanding;
  logic                               err_unmatched_ack;

  modport slave (
    input  req_valid, req_addr, req_width, req_dest, req_opcode, req_is_mem,
    input  hold_off, out_ready, ack_in_valid, ack_in_src_id,
    output arb_won, ack, out_valid, out_addr, out_width, out_dest, out_opcode,
    output out_is_mem, out_source_id, outstanding, err_unmatched_ack
  );

  modport master (
    output req_valid, req_addr, req_width, req_dest, req_opcode, req_is_mem,
    output hold_off, out_ready, ack_in_valid, ack_in_src_id,
    input  arb_won, ack, out_valid, out_addr, out_width, out_dest, out_opcode,
    input  out_is_mem, out_source_id, outstanding, err_unmatched_ack
  );
endinterface

// File: rtl/noc_req_arbiter.sv
// Round-robin arbiter sharing one NoC request port among N_REQ control FSMs.
// Holds the winning request in a one-entry output register, tracks one
// outstanding request per FSM and routes returning acks by source ID.
module noc_req_arbiter #(
  parameter int N_REQ             = 4,
  parameter int ADDR_W            = 10,
  parameter int ADDR_W_ENCODING_W = 3,
  parameter int OPCODE_W          = 2,
  parameter int SRC_ID_W          = 4,
  parameter int BASE_SRC_ID       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_req_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  last;
  logic [N_REQ-1:0]  eligible;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic              grant_en;
  logic [SRC_ID_W:0] ack_off;
  logic              ack_in_range;
  logic [IDX_W-1:0]  ack_idx;
  logic [N_REQ-1:0]  ack_vec;
  logic              err_nxt;
  logic [N_REQ-1:0]  outstanding_nxt;

  // A requester with a request already in flight must not be granted again.
  assign eligible = bus.req_valid & ~bus.outstanding;

  // Round-robin search: first eligible requester starting after the last winner.
  always_comb begin
    int         cand_i;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_i = (int'(last) + k) % N_REQ;
      cand   = IDX_W'(cand_i);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant only when not inhibited and the output slot is free or draining now.
  assign grant_en = ~bus.hold_off & found & (~bus.out_valid | bus.out_ready);

  // Extra MSB catches underflow of src_id - BASE_SRC_ID as out of range.
  assign ack_off      = {1'b0, bus.ack_in_src_id} - (SRC_ID_W+1)'(BASE_SRC_ID);
  assign ack_in_range = (ack_off < (SRC_ID_W+1)'(N_REQ));
  assign ack_idx      = ack_off[IDX_W-1:0];

  // Ack decode and next outstanding mask; a grant in the same cycle sets after the clear.
  always_comb begin
    ack_vec         = '0;
    err_nxt         = 1'b0;
    outstanding_nxt = bus.outstanding;
    if (bus.ack_in_valid) begin
      if (ack_in_range) begin
        ack_vec[ack_idx]         = 1'b1;
        err_nxt                  = ~bus.outstanding[ack_idx];
        outstanding_nxt[ack_idx] = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end
    if (grant_en) outstanding_nxt[winner] = 1'b1;
  end

  // All state and registered outputs; reset drops in-flight work silently.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    if (!rst_n) begin
      last                  <= IDX_W'(N_REQ - 1);
      bus.arb_won           <= '0;
      bus.ack               <= '0;
      bus.err_unmatched_ack <= 1'b0;
      bus.outstanding       <= '0;
      bus.out_valid         <= 1'b0;
      bus.out_addr          <= '0;
      bus.out_width         <= '0;
      bus.out_dest          <= '0;
      bus.out_opcode        <= '0;
      bus.out_is_mem        <= 1'b0;
      bus.out_source_id     <= '0;
    end else begin
      bus.ack               <= ack_vec;
      bus.err_unmatched_ack <= err_nxt;
      bus.outstanding       <= outstanding_nxt;
      bus.arb_won           <= '0;
      if (grant_en) begin
        last                <= winner;
        bus.arb_won[winner] <= 1'b1;
        bus.out_valid       <= 1'b1;
        bus.out_addr        <= bus.req_addr[winner*ADDR_W +: ADDR_W];
        bus.out_width       <= bus.req_width[winner*ADDR_W_ENCODING_W +: ADDR_W_ENCODING_W];
        bus.out_dest        <= bus.req_dest[winner*SRC_ID_W +: SRC_ID_W];
        bus.out_opcode      <= bus.req_opcode[winner*OPCODE_W +: OPCODE_W];
        bus.out_is_mem      <= bus.req_is_mem[winner];
        bus.out_source_id   <= SRC_ID_W'(BASE_SRC_ID) + SRC_ID_W'(winner);
      end else if (bus.out_ready) begin
        bus.out_valid       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_noc_req_arbiter.sv
// Self-checking bench for noc_req_arbiter: directed test-plan steps followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_noc_req_arbiter;
  localparam int N_REQ = 4;
  localparam int ADDR_W = 10;
  localparam int AEW = 3;
  localparam int OPCODE_W = 2;
  localparam int SRC_ID_W = 4;
  localparam int BASE_SRC_ID = 0;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  noc_req_arbiter_if #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .ADDR_W_ENCODING_W(AEW),
    .OPCODE_W(OPCODE_W), .SRC_ID_W(SRC_ID_W)
  ) bus ();

  noc_req_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .ADDR_W_ENCODING_W(AEW),
    .OPCODE_W(OPCODE_W), .SRC_ID_W(SRC_ID_W), .BASE_SRC_ID(BASE_SRC_ID)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected contents of every output after the next edge.
  logic               m_out_valid;
  logic [ADDR_W-1:0]  m_addr;
  logic [AEW-1:0]     m_width;
  logic [SRC_ID_W-1:0] m_dest;
  logic [OPCODE_W-1:0] m_opcode;
  logic               m_is_mem;
  logic [SRC_ID_W-1:0] m_src;
  logic [N_REQ-1:0]   m_outs;
  logic [N_REQ-1:0]   m_won;
  logic [N_REQ-1:0]   m_ack;
  logic               m_err;
  int                 m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int w;
    int idx;
    logic [N_REQ-1:0] outs_old;
    w = -1;
    if (!rst_n) begin
      m_out_valid = 1'b0; m_addr = '0; m_width = '0; m_dest = '0;
      m_opcode = '0; m_is_mem = 1'b0; m_src = '0;
      m_outs = '0; m_won = '0; m_ack = '0; m_err = 1'b0;
      m_last = N_REQ - 1;
      return;
    end
    outs_old = m_outs;
    if (!bus.hold_off && (!m_out_valid || bus.out_ready)) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int i;
        i = (m_last + k) % N_REQ;
        if (w < 0 && ((bus.req_valid >> i) & 1) == 1 && ((outs_old >> i) & 1) == 0) w = i;
      end
    end
    m_ack = '0;
    m_err = 1'b0;
    if (bus.ack_in_valid) begin
      idx = int'(bus.ack_in_src_id) - BASE_SRC_ID;
      if (idx >= 0 && idx < N_REQ) begin
        m_ack  = N_REQ'(1) << idx;
        m_err  = (((outs_old >> idx) & 1) == 0);
        m_outs = m_outs & ~(N_REQ'(1) << idx);
      end else begin
        m_err = 1'b1;
      end
    end
    if (w >= 0) begin
      m_won       = N_REQ'(1) << w;
      m_outs      = m_outs | (N_REQ'(1) << w);
      m_last      = w;
      m_out_valid = 1'b1;
      m_addr      = bus.req_addr[w*ADDR_W +: ADDR_W];
      m_width     = bus.req_width[w*AEW +: AEW];
      m_dest      = bus.req_dest[w*SRC_ID_W +: SRC_ID_W];
      m_opcode    = bus.req_opcode[w*OPCODE_W +: OPCODE_W];
      m_is_mem    = ((bus.req_is_mem >> w) & 1) == 1;
      m_src       = SRC_ID_W'(BASE_SRC_ID + w);
    end else begin
      m_won = '0;
      if (bus.out_ready) m_out_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    check("arb_won", 32'(bus.arb_won), 32'(m_won));
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("outstanding", 32'(bus.outstanding), 32'(m_outs));
    check("err_unmatched_ack", 32'(bus.err_unmatched_ack), 32'(m_err));
    check("out_addr", 32'(bus.out_addr), 32'(m_addr));
    check("out_width", 32'(bus.out_width), 32'(m_width));
    check("out_dest", 32'(bus.out_dest), 32'(m_dest));
    check("out_opcode", 32'(bus.out_opcode), 32'(m_opcode));
    check("out_is_mem", 32'(bus.out_is_mem), 32'(m_is_mem));
    check("out_source_id", 32'(bus.out_source_id), 32'(m_src));
  endtask

  // One clock: predict, take the edge, sample 1 ns later and compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [AEW-1:0] wd,
                         input logic [SRC_ID_W-1:0] d, input logic [OPCODE_W-1:0] op,
                         input logic mem);
    bus.req_addr[i*ADDR_W +: ADDR_W]       = a;
    bus.req_width[i*AEW +: AEW]            = wd;
    bus.req_dest[i*SRC_ID_W +: SRC_ID_W]   = d;
    bus.req_opcode[i*OPCODE_W +: OPCODE_W] = op;
    bus.req_is_mem   = mem ? (bus.req_is_mem | (N_REQ'(1) << i)) : (bus.req_is_mem & ~(N_REQ'(1) << i));
    bus.req_valid    = bus.req_valid | (N_REQ'(1) << i);
  endtask

  task automatic drop_req(input int i);
    bus.req_valid = bus.req_valid & ~(N_REQ'(1) << i);
  endtask

  task automatic send_ack(input int src);
    bus.ack_in_valid  = 1'b1;
    bus.ack_in_src_id = SRC_ID_W'(src);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_width = '0; bus.req_dest = '0;
    bus.req_opcode = '0; bus.req_is_mem = '0; bus.hold_off = 1'b0; bus.out_ready = 1'b0;
    bus.ack_in_valid = 1'b0; bus.ack_in_src_id = '0;

    // Reset state
    tick();
    tick();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_outstanding", 32'(bus.outstanding), 32'd0);
    rst_n = 1'b1;

    // Single request from requester 2
    bus.out_ready = 1'b1;
    set_req(2, 10'h155, 3'd1, 4'd5, 2'd2, 1'b1);
    tick();
    check("single_won", 32'(bus.arb_won), 32'h4);
    check("single_addr", 32'(bus.out_addr), 32'h155);
    check("single_opcode", 32'(bus.out_opcode), 32'd2);
    check("single_src", 32'(bus.out_source_id), 32'd2);
    check("single_outstanding", 32'(bus.outstanding), 32'h4);
    drop_req(2);
    tick();
    check("single_pulse_len", 32'(bus.arb_won), 32'd0);

    // Round-robin from reset: order 0,1,2,3 then 0 again after its ack
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, ADDR_W'(10'h100 + i), AEW'(i), SRC_ID_W'(i + 8), OPCODE_W'(i), i[0]);
    for (int k = 0; k < N_REQ; k++) begin
      tick();
      check("rr_won", 32'(bus.arb_won), 32'(1) << k);
      drop_req(k);
    end
    check("rr_all_outstanding", 32'(bus.outstanding), 32'hf);
    send_ack(BASE_SRC_ID + 0);
    tick();
    check("rr_ack0", 32'(bus.ack), 32'h1);
    bus.ack_in_valid = 1'b0;
    set_req(0, 10'h3aa, 3'd7, 4'd1, 2'd3, 1'b0);
    tick();
    check("rr_wrap_won", 32'(bus.arb_won), 32'h1);
    drop_req(0);

    // Backpressure: requester 1 held, requester 3 waits for out_ready
    do_reset();
    bus.out_ready = 1'b0;
    set_req(1, 10'h0a1, 3'd2, 4'd3, 2'd1, 1'b1);
    set_req(3, 10'h2c3, 3'd4, 4'd6, 2'd0, 1'b0);
    tick();
    check("bp_first_won", 32'(bus.arb_won), 32'h2);
    drop_req(1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_no_grant", 32'(bus.arb_won), 32'd0);
      check("bp_addr_hold", 32'(bus.out_addr), 32'h0a1);
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_second_won", 32'(bus.arb_won), 32'h8);
    check("bp_second_addr", 32'(bus.out_addr), 32'h2c3);
    drop_req(3);

    // Ack routing: matched ack to 3, then out-of-range source 9
    send_ack(3);
    tick();
    check("ack3", 32'(bus.ack), 32'h8);
    check("ack3_outstanding", 32'(bus.outstanding), 32'h2);
    send_ack(9);
    tick();
    check("ack9_none", 32'(bus.ack), 32'd0);
    check("ack9_err", 32'(bus.err_unmatched_ack), 32'd1);
    bus.ack_in_valid = 1'b0;

    // Hold-off: no grant for 3 cycles while handshake and acks proceed
    bus.hold_off = 1'b1;
    set_req(0, 10'h011, 3'd0, 4'd2, 2'd1, 1'b1);
    send_ack(1);
    tick();
    check("ho_ack1", 32'(bus.ack), 32'h2);
    check("ho_drain", 32'(bus.out_valid), 32'd0);
    bus.ack_in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("ho_no_grant", 32'(bus.arb_won), 32'd0);
    end
    bus.hold_off = 1'b0;
    tick();
    check("ho_grant", 32'(bus.arb_won), 32'h1);
    drop_req(0);

    // Reset mid-flight with out_valid=1 and outstanding=0011
    set_req(1, 10'h1f1, 3'd3, 4'd4, 2'd2, 1'b0);
    tick();
    drop_req(1);
    bus.out_ready = 1'b0;
    check("mf_outstanding", 32'(bus.outstanding), 32'h3);
    check("mf_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    check("mf_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mf_rst_outstanding", 32'(bus.outstanding), 32'd0);
    check("mf_rst_addr", 32'(bus.out_addr), 32'd0);
    set_req(3, 10'h333, 3'd1, 4'd1, 2'd1, 1'b1);
    set_req(0, 10'h000, 3'd2, 4'd2, 2'd2, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("mf_last_reset", 32'(bus.arb_won), 32'h1);
    drop_req(0);
    drop_req(3);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (((bus.req_valid >> i) & 1) == 1) begin
          if (((m_outs >> i) & 1) == 1 && $urandom_range(0, 1) == 0) drop_req(i);
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, ADDR_W'($urandom), AEW'($urandom), SRC_ID_W'($urandom),
                  OPCODE_W'($urandom), 1'($urandom));
        end
      end
      bus.hold_off  = ($urandom_range(0, 4) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 5) < 4) send_ack(BASE_SRC_ID + int'($urandom_range(0, N_REQ - 1)));
        else send_ack(int'($urandom_range(0, 15)));
      end else begin
        bus.ack_in_valid = 1'b0;
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/noc_req_arbiter.md
# noc_req_arbiter

Round-robin arbiter that shares the single internal NoC request port among `N_REQ` per-request control FSMs. It latches the winning request into a one-entry output register and pulses `arb_won` back to the winner. It tracks one outstanding request per FSM and routes returning acks to the owner by source ID. It sits between the control FSM array and the NoC/scoreboard request path.

## Interface
- `N_REQ`, 4: number of requesting FSMs (2..8).
- `ADDR_W`, 10: address width.
- `ADDR_W_ENCODING_W`, 3: width-encoding field width.
- `OPCODE_W`, 2: opcode width.
- `SRC_ID_W`, 4: source/dest ID width.
- `BASE_SRC_ID`, 0: requester i owns source ID `BASE_SRC_ID+i`.
- Reset is `rst_n`, synchronous, active-low. The clock is `clk`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `req_valid`, in, N_REQ: per-requester request valid. Held until `arb_won`.
- `req_addr`, in, N_REQ*ADDR_W: flattened; requester i occupies slice [i*ADDR_W +: ADDR_W]. The same slicing rule applies to all flattened fields.
- `req_width`, in, N_REQ*ADDR_W_ENCODING_W: width encoding.
- `req_dest`, in, N_REQ*SRC_ID_W: destination ID.
- `req_opcode`, in, N_REQ*OPCODE_W: opcode.
- `req_is_mem`, in, N_REQ: 1 = memory request, 0 = accelerator request.
- `arb_won`, out, N_REQ: one-cycle grant pulse, one-hot.
- `ack`, out, N_REQ: one-cycle ack pulse to the owning requester.
- `hold_off`, in, 1: inhibits new grants (serializer/scoreboard conflict).
- `out_valid`, out, 1: output request valid.
- `out_ready`, in, 1: downstream accepts the output request.
- `out_addr`, `out_width`, `out_dest`, `out_opcode`, `out_is_mem`, out, field widths: latched winner fields.
- `out_source_id`, out, SRC_ID_W: `BASE_SRC_ID + winner index`.
- `ack_in_valid`, in, 1: ack returning from the NoC.
- `ack_in_src_id`, in, SRC_ID_W: source ID of the returning ack.
- `outstanding`, out, N_REQ: per-requester in-flight status.
- `err_unmatched_ack`, out, 1: one-cycle pulse on a bad ack.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i] & ~outstanding[i]`.
- **Grant condition.** A grant occurs in cycle t when `~hold_off`, at least one requester is eligible, and the slot is free. The slot is free when `~out_valid | out_ready`, so one grant per cycle is sustainable.
- **Round-robin priority.**
  - Search starts at `last+1` and wraps modulo `N_REQ`.
  - `last` updates to the winner on each grant.
  - `last` resets to `N_REQ-1`, so requester 0 has first priority.
- **At the grant edge:**
  - The winner's fields load into the `out_*` registers.
  - `out_valid` is set.
  - `outstanding[w]` is set.
  - `arb_won[w]` is registered high for exactly one cycle.
- **Output hold.** `out_valid` and all `out_*` fields hold stable until `out_ready`. `out_valid & out_ready` with no new grant clears `out_valid`.
- **Ack routing.** On `ack_in_valid`, compute `idx = ack_in_src_id - BASE_SRC_ID`.
  - If `idx < N_REQ`: `ack[idx]` pulses on the next cycle and `outstanding[idx]` clears.
  - If `outstanding[idx]` was already 0, the ack is still forwarded and `err_unmatched_ack` also pulses.
  - If `idx` is out of range (including underflow), the ack is dropped and `err_unmatched_ack` pulses.
- **Simultaneous ack and eligibility.** An ack clearing `outstanding[i]` and a new `req_valid[i]` in the same cycle: i is not eligible that cycle. It becomes eligible the cycle after the clear.
- **Hold-off.** `hold_off` blocks grants only. The output handshake and ack routing continue.
- **Reset.** Reset mid-operation drops the in-flight output request and all outstanding state. No acks are generated for dropped requests.

## Timing
- **Reset values.**
  - `out_valid`, `arb_won`, `ack`, `outstanding`, `err_unmatched_ack` = 0.
  - `out_*` fields = 0.
  - `last` = `N_REQ-1`.
- **Request-to-grant latency.** A request seen eligible at edge t produces `arb_won` and `out_valid` in cycle t+1.
- **Ack latency.** `ack_in_valid` at edge t produces `ack` pulse and `outstanding` clear at t+1.
- **Requester obligation.** The requester drops `req_valid` after seeing `arb_won`. While the requester lingers, the `outstanding` mask prevents a double grant.
- **Throughput.** One grant per cycle while `out_ready` stays high.

## Test plan
- **Single request.** `req_valid=4'b0100`, addr 0x155, opcode 2, `out_ready=1` → `arb_won=4'b0100` one cycle later, `out_addr=0x155`, `out_source_id=2`, `outstanding=4'b0100`.
- **Round-robin.** All four requesters valid after reset, re-asserting after each ack → grant order 0,1,2,3,0, one grant per cycle, never a repeated winner while outstanding.
- **Backpressure.** `out_ready=0` for 5 cycles with requesters 1 and 3 valid → requester 1 fields held stable, no second grant. `out_ready=1` → requester 3 is granted the same cycle.
- **Ack routing.** `ack_in_valid` with `src_id=3` → `ack=4'b1000` next cycle and `outstanding[3]` cleared. `src_id=9` → no ack, `err_unmatched_ack` pulses.
- **Hold-off.** `hold_off=1` for 3 cycles with requester 0 valid → no grant. Grant occurs one cycle after `hold_off` deasserts, while `out_ready` and acks continue to operate.
- **Reset mid-flight.** Assert `rst_n=0` with `out_valid=1` and `outstanding=4'b0011` → all outputs 0 next cycle, `last=3`.
